// File: rtl/mul16_seq.sv
// mul16_seq: sequential shift-and-add unsigned multiplier.
// One partial product per clock (WIDTH clocks per multiply), a one-cycle
// DONE state with a done pulse, and a product register that only changes
// on completion or reset.

// and16: bitwise AND gate cell used to form each partial product.
module and16 #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] z
);

   assign z = x & y;

endmodule

module mul16_seq #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int              CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   logic [WIDTH-1:0]     mcand_r;
   logic [WIDTH-1:0]     mplier_r;
   logic [CW-1:0]        count;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     pp;
   logic [2*WIDTH-1:0]   addend;
   logic [2*WIDTH-1:0]   acc_next;

   // Partial product: multiplicand gated by the current multiplier bit.
   and16 #(.WIDTH(WIDTH)) u_and (
      .x (mcand_r),
      .y ({WIDTH{mplier_r[count]}}),
      .z (pp)
   );

   // The 2*WIDTH-bit accumulator cannot overflow: (2^W-1)^2 < 2^(2W).
   assign addend   = {{WIDTH{1'b0}}, pp} << count;
   assign acc_next = acc + addend;

   // Control FSM and datapath registers; outputs are registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         product  <= '0;
         acc      <= '0;
         count    <= '0;
         mcand_r  <= '0;
         mplier_r <= '0;
      end else if (state == RUN) begin
         // NOTE: non-blocking assignments let every register here sample the
         // pre-edge values of acc/count, so acc_next and the LAST test agree.
         acc   <= acc_next;
         count <= count + CW'(1);
         if (count == LAST) begin
            product <= acc_next;
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
         end
      end else begin
         // IDLE and DONE behave alike: accept start, otherwise rest in IDLE.
         done <= 1'b0;
         busy <= start;
         if (start) begin
            mcand_r  <= a;
            mplier_r <= b;
            acc      <= '0;
            count    <= '0;
            state    <= RUN;
         end else begin
            state    <= IDLE;
         end
      end
   end

endmodule
